// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared scan state type and default geometry for the pixel mapping stage
package pixel_pkg;

    localparam int DEF_PIXEL_DATA_WIDTH  = 10;
    localparam int DEF_ENGINE_DATA_WIDTH = 25;
    localparam int DEF_SCREEN_W          = 640;
    localparam int DEF_SCREEN_H          = 480;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/pixel_scan_counter.sv
// rtl/pixel_scan_counter.sv - raster x/y counter that wraps to the origin after the last pixel
module pixel_scan_counter #(
    parameter int PW = 10,
    parameter int W  = 640,
    parameter int H  = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [PW-1:0] x_o,
    output logic [PW-1:0] y_o,
    output logic          last_o
);

    localparam logic [PW-1:0] X_LAST = PW'(W - 1);
    localparam logic [PW-1:0] Y_LAST = PW'(H - 1);

    logic [PW-1:0] x_q, x_d;
    logic [PW-1:0] y_q, y_d;
    logic          x_at_end;

    assign x_at_end = (x_q == X_LAST);
    assign last_o   = x_at_end && (y_q == Y_LAST);
    assign x_o      = x_q;
    assign y_o      = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (inc_i) begin
            if (x_at_end) begin
                x_d = '0;
                // Last pixel of the frame returns to the origin ready for the next frame
                y_d = last_o ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/pixel_scan_ctrl.sv
// rtl/pixel_scan_ctrl.sv - frame sequencer driving the mapper enable and raster coordinates
module pixel_scan_ctrl
    import pixel_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH  = DEF_PIXEL_DATA_WIDTH,
    parameter int ENGINE_DATA_WIDTH = DEF_ENGINE_DATA_WIDTH,
    parameter int SCREEN_W          = DEF_SCREEN_W,
    parameter int SCREEN_H          = DEF_SCREEN_H
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                continuous,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
    input  logic                                full_queue,
    input  logic                                distributor_ready,
    output logic                                map_en,
    output logic        [PIXEL_DATA_WIDTH-1:0]  pixel_x,
    output logic        [PIXEL_DATA_WIDTH-1:0]  pixel_y,
    output logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
    output logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
    output logic                                busy,
    output logic                                frame_done,
    output logic [15:0]                         frame_count
);

    scan_state_t state_q, state_d;

    logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_q, y_offset_q;
    logic                                busy_q;
    logic                                frame_done_q;
    logic [15:0]                         frame_count_q;

    logic accept;
    logic last_pixel;
    logic start_frame;
    logic latch_offsets;
    logic frame_end;

    // The mapper qualifies its capture with exactly this term, so both stay in lockstep
    assign accept        = (state_q == SCAN) && !full_queue && !distributor_ready;
    assign frame_end     = accept && last_pixel;
    assign start_frame   = (state_q == IDLE) && start;
    assign latch_offsets = start_frame || ((state_q == DONE) && continuous);

    pixel_scan_counter #(
        .PW (PIXEL_DATA_WIDTH),
        .W  (SCREEN_W),
        .H  (SCREEN_H)
    ) u_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_frame),
        .inc_i   (accept),
        .x_o     (pixel_x),
        .y_o     (pixel_y),
        .last_o  (last_pixel)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (frame_end) state_d = DONE;
            DONE:    state_d = continuous ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            x_offset_q    <= '0;
            y_offset_q    <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= (state_d != IDLE);
            frame_done_q <= frame_end;
            if (frame_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            // Offsets only move at a frame boundary so a pan/zoom never tears a frame
            if (latch_offsets) begin
                x_offset_q <= x_offset_in;
                y_offset_q <= y_offset_in;
            end
        end
    end

    assign map_en      = (state_q == SCAN);
    assign x_offset    = x_offset_q;
    assign y_offset    = y_offset_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// tb/tb_pixel_scan_ctrl.sv - scoreboard bench for pixel_scan_ctrl on a 4x3 frame
module tb_pixel_scan_ctrl;

    localparam int PW = 10;
    localparam int EW = 25;
    localparam int SW = 4;
    localparam int SH = 3;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 continuous;
    logic signed [EW-1:0] x_offset_in;
    logic signed [EW-1:0] y_offset_in;
    logic                 full_queue;
    logic                 distributor_ready;
    logic                 map_en;
    logic [PW-1:0]        pixel_x;
    logic [PW-1:0]        pixel_y;
    logic signed [EW-1:0] x_offset;
    logic signed [EW-1:0] y_offset;
    logic                 busy;
    logic                 frame_done;
    logic [15:0]          frame_count;

    typedef struct {
        logic [PW-1:0] x;
        logic [PW-1:0] y;
    } coord_t;

    coord_t sb[$];
    coord_t mon_e;
    int checks   = 0;
    int failures = 0;

    pixel_scan_ctrl #(
        .PIXEL_DATA_WIDTH  (PW),
        .ENGINE_DATA_WIDTH (EW),
        .SCREEN_W          (SW),
        .SCREEN_H          (SH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .continuous        (continuous),
        .x_offset_in       (x_offset_in),
        .y_offset_in       (y_offset_in),
        .full_queue        (full_queue),
        .distributor_ready (distributor_ready),
        .map_en            (map_en),
        .pixel_x           (pixel_x),
        .pixel_y           (pixel_y),
        .x_offset          (x_offset),
        .y_offset          (y_offset),
        .busy              (busy),
        .frame_done        (frame_done),
        .frame_count       (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every mapper capture must match the next coordinate expected in raster order
    always @(negedge clk) begin
        if (!reset && map_en && !full_queue && !distributor_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow capture at (%0d,%0d) with nothing expected", pixel_x, pixel_y);
            end else begin
                mon_e = sb.pop_front();
                if (pixel_x !== mon_e.x || pixel_y !== mon_e.y) begin
                    failures++;
                    $display("FAIL sb_coord got (%0d,%0d) expected (%0d,%0d)", pixel_x, pixel_y, mon_e.x, mon_e.y);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        coord_t c;
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                c.x = PW'(x);
                c.y = PW'(y);
                sb.push_back(c);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic run_scan(output int n);
        n = 0;
        while (map_en === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic begin_frame();
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (map_en !== 1'b0 || pixel_x !== '0 || pixel_y !== '0 || x_offset !== '0 || y_offset !== '0 ||
            busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_values got map_en=%b x=%0d y=%0d xo=%0d yo=%0d busy=%b done=%b cnt=%0d expected all zero",
                     map_en, pixel_x, pixel_y, x_offset, y_offset, busy, frame_done, frame_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_small_frame();
        int n;
        do_reset();
        begin_frame();
        checks++;
        if (map_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_latency got map_en=%b busy=%b expected 1 1", map_en, busy);
        end
        run_scan(n);
        checks++;
        if (n != SW * SH) begin
            failures++;
            $display("FAIL small_scan_len got %0d expected %0d", n, SW * SH);
        end
        checks++;
        if (frame_done !== 1'b1 || frame_count !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL small_done got done=%b cnt=%0d busy=%b expected 1 1 1", frame_done, frame_count, busy);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || map_en !== 1'b0 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL small_idle got done=%b busy=%b map_en=%b cnt=%0d expected 0 0 0 1",
                     frame_done, busy, map_en, frame_count);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int hold;
        do_reset();
        begin_frame();
        n = 0;
        hold = 0;
        while (map_en === 1'b1 && n < 200) begin
            n++;
            if (pixel_x == 2 && pixel_y == 1 && hold < 5) begin
                full_queue        = (hold < 3);
                distributor_ready = (hold >= 3);
                hold++;
            end else begin
                full_queue        = 1'b0;
                distributor_ready = 1'b0;
            end
            step();
        end
        full_queue        = 1'b0;
        distributor_ready = 1'b0;
        checks++;
        if (hold != 5) begin
            failures++;
            $display("FAIL bp_hold got %0d stalled cycles at (2,1) expected 5", hold);
        end
        checks++;
        if (n != 17) begin
            failures++;
            $display("FAIL bp_scan_len got %0d expected 17", n);
        end
        step();
    endtask

    task automatic test_offset_latch();
        int n;
        do_reset();
        x_offset_in = 25'sh0100000;
        y_offset_in = -25'sd7;
        begin_frame();
        checks++;
        if (x_offset !== 25'sh0100000 || y_offset !== -25'sd7) begin
            failures++;
            $display("FAIL ofs_latch got %h %h expected 0100000 %h", x_offset, y_offset, -25'sd7);
        end
        for (int i = 0; i < 5; i++) step();
        x_offset_in = 25'sh0200000;
        y_offset_in = 25'sd123;
        step();
        checks++;
        if (x_offset !== 25'sh0100000 || y_offset !== -25'sd7) begin
            failures++;
            $display("FAIL ofs_midframe got %h %h expected 0100000 %h", x_offset, y_offset, -25'sd7);
        end
        run_scan(n);
        step();
        checks++;
        if (x_offset !== 25'sh0100000) begin
            failures++;
            $display("FAIL ofs_idle got %h expected 0100000", x_offset);
        end
        begin_frame();
        checks++;
        if (x_offset !== 25'sh0200000 || y_offset !== 25'sd123) begin
            failures++;
            $display("FAIL ofs_relatch got %h %h expected 0200000 %h", x_offset, y_offset, 25'sd123);
        end
        run_scan(n);
        step();
    endtask

    task automatic test_continuous();
        int cyc;
        int nd;
        int t[3];
        do_reset();
        continuous = 1'b1;
        push_frame();
        push_frame();
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        nd = 0;
        while (nd < 3 && cyc < 200) begin
            cyc++;
            if (cyc == 5) start = 1'b1;
            if (frame_done === 1'b1) begin
                t[nd] = cyc;
                nd++;
                checks++;
                if (frame_count !== 16'(nd)) begin
                    failures++;
                    $display("FAIL cont_count got %0d expected %0d", frame_count, nd);
                end
                if (nd == 3) begin
                    continuous = 1'b0;
                    start      = 1'b0;
                end
            end
            if (nd < 3) step();
        end
        checks++;
        if (nd != 3 || (t[1] - t[0]) != 13 || (t[2] - t[1]) != 13) begin
            failures++;
            $display("FAIL cont_spacing got pulses=%0d gaps=%0d,%0d expected 3 pulses gaps 13,13",
                     nd, t[1] - t[0], t[2] - t[1]);
        end
        step();
        checks++;
        if (busy !== 1'b0 || map_en !== 1'b0 || frame_count !== 16'd3) begin
            failures++;
            $display("FAIL cont_end got busy=%b map_en=%b cnt=%0d expected 0 0 3", busy, map_en, frame_count);
        end
    endtask

    task automatic test_reset_mid_frame();
        int g;
        begin_frame();
        g = 0;
        while (!(pixel_x == 1 && pixel_y == 2) && g < 50) begin
            g++;
            step();
        end
        checks++;
        if (pixel_x !== 10'd1 || pixel_y !== 10'd2 || map_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_reach got (%0d,%0d) map_en=%b expected (1,2) 1", pixel_x, pixel_y, map_en);
        end
        reset = 1'b1;
        step();
        checks++;
        if (map_en !== 1'b0 || pixel_x !== '0 || pixel_y !== '0 || x_offset !== '0 || y_offset !== '0 ||
            busy !== 1'b0 || frame_done !== 1'b0 || frame_count !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid got map_en=%b x=%0d y=%0d xo=%0d yo=%0d busy=%b done=%b cnt=%0d expected all zero",
                     map_en, pixel_x, pixel_y, x_offset, y_offset, busy, frame_done, frame_count);
        end
        reset = 1'b0;
        sb.delete();
        step();
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || map_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_after got done=%b busy=%b map_en=%b expected 0 0 0", frame_done, busy, map_en);
        end
    endtask

    task automatic test_last_pixel_stall();
        int g;
        do_reset();
        begin_frame();
        g = 0;
        while (!(pixel_x == SW - 1 && pixel_y == SH - 1) && g < 50) begin
            g++;
            step();
        end
        full_queue = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (map_en !== 1'b1 || frame_done !== 1'b0 || pixel_x !== 10'd3 || pixel_y !== 10'd2) begin
                failures++;
                $display("FAIL last_stall cycle %0d got map_en=%b done=%b (%0d,%0d) expected 1 0 (3,2)",
                         i, map_en, frame_done, pixel_x, pixel_y);
            end
        end
        full_queue = 1'b0;
        step();
        checks++;
        if (frame_done !== 1'b1 || map_en !== 1'b0 || frame_count !== 16'd1) begin
            failures++;
            $display("FAIL last_release got done=%b map_en=%b cnt=%0d expected 1 0 1", frame_done, map_en, frame_count);
        end
        step();
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL last_idle got busy=%b done=%b expected 0 0", busy, frame_done);
        end
    endtask

    initial begin
        reset             = 1'b1;
        start             = 1'b0;
        continuous        = 1'b0;
        x_offset_in       = '0;
        y_offset_in       = '0;
        full_queue        = 1'b0;
        distributor_ready = 1'b0;

        test_reset();
        test_small_frame();
        test_backpressure();
        test_offset_latch();
        test_continuous();
        test_reset_mid_frame();
        test_last_pixel_stall();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d uncaptured coordinates expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_scan_ctrl.md
# pixel_scan_ctrl

Frame sequencer for the pixel-to-complex mapping stage. It walks pixel coordinates in raster order and drives the mapper's enable, which makes `en` high exactly while a frame is in progress. Coordinates advance only on cycles where the mapper actually captures, using the same `full_queue`/`distributor_ready` qualification. Offsets are latched once per frame, so a pan/zoom update never tears a frame.

## Interface
- `PIXEL_DATA_WIDTH`, 10: coordinate width.
- `ENGINE_DATA_WIDTH`, 25: signed fixed-point offset width.
- `SCREEN_W`, 640: pixels per line. Must satisfy 2 ≤ `SCREEN_W` ≤ 2^`PIXEL_DATA_WIDTH`.
- `SCREEN_H`, 480: lines per frame. Same bound as `SCREEN_W`.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: request one frame; level-sampled in IDLE.
- `continuous` in 1: when high at end of frame, the next frame begins without `start`.
- `x_offset_in` in `ENGINE_DATA_WIDTH` signed: requested real offset.
- `y_offset_in` in `ENGINE_DATA_WIDTH` signed: requested imaginary offset.
- `full_queue` in 1: downstream queue full; stalls the scan.
- `distributor_ready` in 1: distributor busy-handshake; stalls the scan while high.
- `map_en` out 1: enable to the mapper.
- `pixel_x` out `PIXEL_DATA_WIDTH`: current column.
- `pixel_y` out `PIXEL_DATA_WIDTH`: current row.
- `x_offset` out `ENGINE_DATA_WIDTH` signed: frame-latched real offset.
- `y_offset` out `ENGINE_DATA_WIDTH` signed: frame-latched imaginary offset.
- `busy` out 1: high in SCAN and DONE.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `frame_count` out 16: completed frames, wraps at 2^16.

## Operation
- **States:** IDLE, SCAN, DONE.
- **IDLE → SCAN** when `start`=1.
  - Latch `x_offset_in`/`y_offset_in` into `x_offset`/`y_offset`.
  - Set `pixel_x`=`pixel_y`=0.
- **`accept`** = (state==SCAN) & ~`full_queue` & ~`distributor_ready`.
- **On `accept`:**
  - If `pixel_x`==`SCREEN_W`-1: `pixel_x`←0 and `pixel_y`←`pixel_y`+1.
  - Otherwise `pixel_x`←`pixel_x`+1.
- **Last pixel:** `accept` at (`SCREEN_W`-1, `SCREEN_H`-1) → DONE. Counters go to 0 and `frame_count` increments.
- **DONE, one cycle:**
  - If `continuous`=1 → SCAN, re-latching offsets.
  - Else → IDLE.
- **`start` in SCAN/DONE** is ignored. No queued request.
- **Offset inputs** changing mid-frame have no effect until the next latch.
- **Stall:** while `full_queue` or `distributor_ready` is high, coordinates hold and `map_en` stays high. The mapper gates itself on the same condition.

## Timing
- **Reset values:** state IDLE; `map_en`=0, `pixel_x`=`pixel_y`=0, `x_offset`=`y_offset`=0, `busy`=0, `frame_done`=0, `frame_count`=0.
- **Outputs** are registered, except `map_en`, which equals (state==SCAN).
- **Start latency:** `start` sampled at edge N → `map_en`=1 and coords (0,0) from edge N+1.
- **Mapper capture:** it captures the coordinates present at an `accept` edge. The next coordinates appear on the same edge.
- **Unstalled frame length:** exactly `SCREEN_W`×`SCREEN_H` cycles in SCAN.
- **`frame_done`** is high for the one DONE cycle. It coincides with the `frame_count` increment being visible.
- **Continuous mode:** one dead cycle (DONE, `map_en`=0) between frames.
- **Reset mid-frame:** IDLE next edge; no `frame_done`; `frame_count` cleared.
- **Stall on last pixel:** DONE is entered only after the stall clears and `accept` fires.

## Structure
- **Shared package `pixel_pkg`:**
  - `scan_state_t` enum (IDLE/SCAN/DONE).
  - Default `SCREEN_W`/`SCREEN_H`, `PIXEL_DATA_WIDTH` and `ENGINE_DATA_WIDTH` constants, shared with the mapper.
- **Sub-module `pixel_scan_counter`:** x/y raster counter with `inc`, `clear` and `last` outputs. It is parameterised by W/H.

## Test plan
- **Small frame, no stalls:** `SCREEN_W`=4, `SCREEN_H`=3, pulse `start` → 12 consecutive `map_en` cycles with coords (0,0),(1,0)…(3,2), then `frame_done` one cycle, `frame_count`=1, IDLE.
- **Backpressure:** `full_queue`=1 for 3 cycles at (2,1), then `distributor_ready`=1 for 2 cycles → coords hold at (2,1) for 5 cycles. Total SCAN = 17 cycles.
- **Offset latching:** `x_offset_in`=0x0100000 at start, changed to 0x0200000 mid-frame → `x_offset` stays 0x0100000 until the next frame's latch.
- **Continuous mode:** `continuous`=1 for 3 frames → `frame_done` pulses 13 cycles apart; `frame_count` reaches 3; `start` held high mid-frame has no effect.
- **Reset mid-frame:** `reset` at (1,2) → next cycle all outputs at reset values and no `frame_done`.
- **Stall on last pixel:** `full_queue`=1 at (3,2) for 4 cycles → DONE entered only after release; `frame_done` on the following cycle.
